b12_auto_player: RTL

- Automated opponent for the b12 memory game; the other end of its speaker/key interface.
- Listens to the game's `speaker` square wave and decodes each tone from its half-period.
- Records the tone sequence the game plays, then replays it through one-hot `k` presses.
- Sits beside b12 in the game testbench/SoC: b12 outputs feed this block's inputs, and this block's `k`/`start` feed b12.

---
 rtl/b12_auto_player_if.sv | 26 ++
 rtl/b12_auto_player.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b12_auto_player_if.sv
// Speaker/key link between the b12 game and its automated opponent.
// master: the auto player (drives start/k, listens to speaker/nl/nloss).
// slave:  the b12 game side.
interface b12_auto_player_if;
   logic       speaker;
   logic [3:0] nl;
   logic       nloss;
   logic       start;
   logic [3:0] k;

   modport master (
      input  speaker,
      input  nl,
      input  nloss,
      output start,
      output k
   );

   modport slave (
      output speaker,
      output nl,
      output nloss,
      input  start,
      input  k
   );
endinterface

// File: rtl/b12_auto_player.sv
// b12_auto_player: automated opponent for the b12 memory game.
// Decodes tones from the speaker half-period, records the played sequence
// and replays it as one-hot key presses.
// Optional feature macro: B12_AUTO_PLAYER_NL_CHECK_EN adds the sticky nl_err
// output that flags a light pattern not matching the declared tone.
module b12_auto_player #(
   parameter int MATCH_CNT   = 3,
   parameter int GAP_CYC     = 32,
   parameter int PRESS_CYC   = 8,
   parameter int RELEASE_CYC = 8,
   parameter int MAX_SEQ     = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   b12_auto_player_if.master gif,
   output logic              tone_valid,
   output logic [2:0]        tone_id,
   output logic [4:0]        seq_len,
   output logic              won,
   output logic              lost,
   output logic              busy
`ifdef B12_AUTO_PLAYER_NL_CHECK_EN
   ,
   output logic              nl_err
`endif
);

   localparam int PTR_W = $clog2(MAX_SEQ);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_LISTEN  = 3'd2;
   localparam logic [2:0] S_PRESS   = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam logic [2:0] TONE_WIN  = 3'd4;
   localparam logic [2:0] TONE_LOSS = 3'd5;

   localparam logic [PTR_W:0]   P_ONE = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] R_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

   // Recorded-length saturation: the 5-bit length port tops out at 31.
   function automatic logic [4:0] sat_len(input logic [PTR_W:0] n);
      if (int'(n) > 31) return 5'd31;
      return 5'(n);
   endfunction

   // edge detector / half-period counter
   logic             spk_q;
   logic             spk_edge;
   logic [5:0]       hp_cnt_q, hp_cnt_d;

   // half-period decoder and match tracking
   logic             dec_hit;
   logic [2:0]       dec_id;
   logic [3:0]       mcnt_q, mcnt_d;
   logic [2:0]       last_id_q, last_id_d;
   logic             armed_q, armed_d;
   logic             declare;
   logic             tone_valid_q, tone_valid_d;
   logic [2:0]       tone_id_q, tone_id_d;

   // control FSM
   logic             nloss_q;
   logic             nloss_fall;
   logic [2:0]       state_q, state_d;
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   rd_nxt;
   logic [7:0]       cyc_q, cyc_d;
   logic [4:0]       seq_len_q, seq_len_d;
   logic             won_q, won_d;
   logic             lost_q, lost_d;
   logic             mem_we;
   logic [1:0]       mem_q [MAX_SEQ];

`ifdef B12_AUTO_PLAYER_NL_CHECK_EN
   logic             nl_err_q, nl_err_d;
`else
   logic             nl_unused;
   assign nl_unused = ^gif.nl;
`endif

   assign spk_edge   = (gif.speaker != spk_q);
   assign nloss_fall = nloss_q & ~gif.nloss;
   assign rd_nxt     = {1'b0, rd_ptr_q} + P_ONE;

   // Map the half-period measured at an edge onto a tone id.
   always_comb begin
      dec_hit = 1'b1;
      dec_id  = 3'd0;
      case (hp_cnt_q)
         6'd4:    dec_id = 3'd0;
         6'd5:    dec_id = 3'd1;
         6'd6:    dec_id = 3'd2;
         6'd7:    dec_id = 3'd3;
         6'd8:    dec_id = TONE_WIN;
         6'd3:    dec_id = TONE_LOSS;
         default: dec_hit = 1'b0;
      endcase
   end

   // Count consecutive matching edges and declare a tone once per burst.
   always_comb begin
      hp_cnt_d     = (hp_cnt_q == 6'd63) ? hp_cnt_q : hp_cnt_q + 6'd1;
      mcnt_d       = mcnt_q;
      last_id_d    = last_id_q;
      armed_d      = armed_q;
      declare      = 1'b0;
      tone_id_d    = tone_id_q;
`ifdef B12_AUTO_PLAYER_NL_CHECK_EN
      nl_err_d     = nl_err_q;
`endif
      if (spk_edge) begin
         hp_cnt_d = 6'd1;
         if (!dec_hit) begin
            mcnt_d = 4'd0;
         end else if (mcnt_q != 4'd0 && dec_id == last_id_q) begin
            if (int'(mcnt_q) < MATCH_CNT) mcnt_d = mcnt_q + 4'd1;
         end else begin
            // a different id starts a new tone, so it may be declared again
            if (dec_id != last_id_q) armed_d = 1'b1;
            mcnt_d    = 4'd1;
            last_id_d = dec_id;
         end
         if (dec_hit && armed_d && int'(mcnt_d) == MATCH_CNT) begin
            declare   = 1'b1;
            armed_d   = 1'b0;
            tone_id_d = dec_id;
`ifdef B12_AUTO_PLAYER_NL_CHECK_EN
            if (!dec_id[2] && gif.nl != (4'b0001 << dec_id[1:0])) nl_err_d = 1'b1;
`endif
         end
      end else if (int'(hp_cnt_q) >= GAP_CYC) begin
         // a silent speaker ends the burst
         armed_d = 1'b1;
         mcnt_d  = 4'd0;
      end
      tone_valid_d = declare;
   end

   // Game-play sequencing: start, listen/record, replay, abort on win/loss.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cyc_d     = cyc_q;
      seq_len_d = seq_len_q;
      won_d     = won_q;
      lost_d    = lost_q;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_START;
         end
         S_START: begin
            wr_ptr_d  = '0;
            seq_len_d = '0;
            won_d     = 1'b0;
            lost_d    = 1'b0;
            state_d   = S_LISTEN;
         end
         S_LISTEN: begin
            if (tone_valid_q) begin
               if (tone_id_q == TONE_WIN) begin
                  won_d   = 1'b1;
                  state_d = S_IDLE;
               end else if (tone_id_q == TONE_LOSS) begin
                  lost_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (int'(wr_ptr_q) < MAX_SEQ) begin
                  // a full memory silently drops further tones
                  mem_we    = 1'b1;
                  wr_ptr_d  = wr_ptr_q + P_ONE;
                  seq_len_d = sat_len(wr_ptr_q + P_ONE);
               end
            end else if (wr_ptr_q != '0 && int'(hp_cnt_q) >= GAP_CYC) begin
               rd_ptr_d = '0;
               cyc_d    = '0;
               state_d  = S_PRESS;
            end
         end
         S_PRESS: begin
            if (int'(cyc_q) == PRESS_CYC - 1) begin
               cyc_d   = '0;
               state_d = S_RELEASE;
            end else begin
               cyc_d = cyc_q + 8'd1;
            end
         end
         S_RELEASE: begin
            if (int'(cyc_q) == RELEASE_CYC - 1) begin
               cyc_d    = '0;
               rd_ptr_d = rd_ptr_q + R_ONE;
               if (rd_nxt == wr_ptr_q) begin
                  wr_ptr_d = '0;
                  state_d  = S_LISTEN;
               end else begin
                  state_d = S_PRESS;
               end
            end else begin
               cyc_d = cyc_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // win/loss tones still end the game while replaying
      if ((state_q == S_PRESS || state_q == S_RELEASE) && tone_valid_q) begin
         if (tone_id_q == TONE_WIN) begin
            won_d   = 1'b1;
            state_d = S_IDLE;
         end else if (tone_id_q == TONE_LOSS) begin
            lost_d  = 1'b1;
            state_d = S_IDLE;
         end
      end
      if (state_q != S_IDLE && nloss_fall) begin
         lost_d  = 1'b1;
         state_d = S_IDLE;
      end
   end

   // State registers for the detector and the FSM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         spk_q        <= 1'b0;
         hp_cnt_q     <= '0;
         mcnt_q       <= '0;
         last_id_q    <= '0;
         armed_q      <= 1'b1;
         tone_valid_q <= 1'b0;
         tone_id_q    <= '0;
         nloss_q      <= 1'b0;
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cyc_q        <= '0;
         seq_len_q    <= '0;
         won_q        <= 1'b0;
         lost_q       <= 1'b0;
`ifdef B12_AUTO_PLAYER_NL_CHECK_EN
         nl_err_q     <= 1'b0;
`endif
      end else begin
         spk_q        <= gif.speaker;
         hp_cnt_q     <= hp_cnt_d;
         mcnt_q       <= mcnt_d;
         last_id_q    <= last_id_d;
         armed_q      <= armed_d;
         tone_valid_q <= tone_valid_d;
         tone_id_q    <= tone_id_d;
         nloss_q      <= gif.nloss;
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cyc_q        <= cyc_d;
         seq_len_q    <= seq_len_d;
         won_q        <= won_d;
         lost_q       <= lost_d;
`ifdef B12_AUTO_PLAYER_NL_CHECK_EN
         nl_err_q     <= nl_err_d;
`endif
      end
   end

   // Sequence memory; contents need no reset because wr_ptr gates reads.
   always_ff @(posedge clock) begin
      if (mem_we) mem_q[wr_ptr_q[PTR_W-1:0]] <= tone_id_q[1:0];
   end

   assign gif.start  = (state_q == S_START);
   assign gif.k      = (state_q == S_PRESS) ? (4'b0001 << mem_q[rd_ptr_q]) : 4'b0000;
   assign tone_valid = tone_valid_q;
   assign tone_id    = tone_id_q;
   assign seq_len    = seq_len_q;
   assign won        = won_q;
   assign lost       = lost_q;
   assign busy       = (state_q != S_IDLE);
`ifdef B12_AUTO_PLAYER_NL_CHECK_EN
   assign nl_err     = nl_err_q;
`endif

endmodule
